shift_pipe: RTL
===============

SHIFT_PIPE -- requirements
Module: shift_pipe

Interface
REQ-001 The block SHALL have parameter XLEN, default 64, giving the operand and result width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter STAGES, default 2, giving the number of register stages; legal range is 1 to log2(XLEN).
REQ-003 The block SHALL have parameter TAG_W, default 5, giving the width of the sideband tag carried with each operation.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous and active-low.
REQ-006 flush  input  1  synchronous kill of all in-flight operations.
REQ-007 in_valid  input  1  operation offered.
REQ-008 in_ready  output  1  block accepts the operation this cycle.
REQ-009 in_a  input  XLEN  operand to be shifted.
REQ-010 in_shamt  input  6  shift amount; only the low log2(XLEN) bits are used, or the low 5 bits in word mode.
REQ-011 in_op  input  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR (rotate right).
REQ-012 in_word  input  1  32-bit word mode (W variants); ignored when XLEN=32.
REQ-013 in_tag  input  TAG_W  sideband tag, returned unchanged with the result.
REQ-014 out_valid  output  1  result available.
REQ-015 out_ready  input  1  consumer takes the result this cycle.
REQ-016 out_result  output  XLEN  shifted value.
REQ-017 out_tag  output  TAG_W  tag of the operation that produced out_result.

Function
REQ-018 An operation SHALL be accepted on a rising edge where in_valid and in_ready are both 1.
REQ-019 A result SHALL be consumed on a rising edge where out_valid and out_ready are both 1.
REQ-020 Shift amount bits SHALL be split across the stages, LSB group first, with remainder bits going to the earliest stages.
  - Each stage applies its partial shift and then registers the result.
REQ-021 With no backpressure, out_valid SHALL rise exactly STAGES cycles after acceptance.
  - Throughput is one operation per cycle.
REQ-022 Each stage register SHALL advance when it is empty or when its downstream register advances or is consumed.
  - in_ready = stage-0 empty or stage-0 advancing.
  - in_ready SHALL NOT depend combinationally on in_valid.
REQ-023 A stalled stage SHALL hold its data, op, shamt remainder and tag unchanged; no operation is ever dropped or duplicated.
REQ-024 SLL SHALL zero-fill from the LSB; SRL SHALL zero-fill from the MSB; SRA SHALL fill with the operand MSB.
  - A shift amount of 0 SHALL return the operand unchanged.
REQ-025 ROR SHALL rotate: bits shifted out of the LSB re-enter at the MSB.
REQ-026 Word mode SHALL pre-condition the operand before stage 0, using only shamt[4:0]:
  - SRL: zero-extend in_a[31:0].
  - SRA: sign-extend in_a[31:0].
  - ROR: operand becomes {in_a[31:0], in_a[31:0]}.
  - SLL: in_a unchanged.
REQ-027 In word mode, out_result SHALL be the low 32 result bits sign-extended from bit 31.
REQ-028 When flush is 1, all stage valid bits SHALL clear on that edge; data registers are don't-care.
  - An input offered in the same cycle as flush SHALL NOT be accepted (in_ready forced 0 while flush=1).
  - out_valid SHALL be 0 on the next cycle.
REQ-029 Flush and rst_n SHALL take precedence over any simultaneous handshake.

Reset
REQ-030 While rst_n=0, all stage valid bits, out_valid, out_result and out_tag SHALL be 0 immediately, independent of clk.
REQ-031 After reset release, in_ready SHALL be 1 on the first cycle.
REQ-032 Reset asserted mid-operation SHALL discard all in-flight operations; no result appears after release.

Structure
REQ-033 Op encodings (OP_SLL, OP_SRL, OP_SRA, OP_ROR) SHALL live in shared package shift_pkg, reused by the ALU decoder.
REQ-034 One sub-module, shift_stage, SHALL implement one partial-shift-plus-register slice with its valid/advance logic.
  - shift_pipe instantiates STAGES copies in a generate loop.

Verification
REQ-035 XLEN=64, STAGES=2, SRA, a=0x8000000000000000, shamt=4, out_ready=1 -> 0xF800000000000000 with matching tag exactly 2 cycles after acceptance.
REQ-036 Word SRAW, a=0x0000000080000000, shamt=4 -> 0xFFFFFFFFF8000000; word SRLW same operands -> 0x0000000008000000; RORW a=0x12345678, shamt=8 -> 0x0000000078123456.
REQ-037 Back-to-back 8 operations with tags 0-7 and out_ready low for cycles 3-5 -> all 8 results emerge in order with correct tags; in_ready drops once the pipe fills; none lost or repeated.
REQ-038 Flush asserted with 2 operations in flight and in_valid=1 -> out_valid 0 next cycle; the flushed ops never appear; the input is not accepted that cycle.
REQ-039 rst_n pulsed low mid-stream -> outputs 0 asynchronously; in_ready=1 on the first cycle after release; no stale results.
REQ-040 Exhaustive sweep, all ops, shamt 0..63, a=0x8000000000000001 for STAGES=1,3,6 -> every result matches the reference model (SLL shamt=63 -> 0x8000000000000000; ROR shamt=1 -> 0xC000000000000000).

Source files
------------

// File: rtl/shift_pkg.sv
// Shared shifter definitions: op encodings (also used by the ALU decoder) and
// helpers that split the shift-amount bits across pipeline stages.
package shift_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROR = 2'b11
    } shift_op_e;

    localparam int SHAMT_W = 6;

    // Shift-amount bits owned by stage idx; leftover bits go to the earliest stages.
    function automatic int stage_bits(input int total, input int stages, input int idx);
        return total / stages + ((idx < (total % stages)) ? 1 : 0);
    endfunction

    function automatic int stage_lo(input int total, input int stages, input int idx);
        int lo;
        lo = 0;
        for (int j = 0; j < idx; j++) begin
            lo += stage_bits(total, stages, j);
        end
        return lo;
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One pipeline slice: applies the partial shift selected by shamt[SH_LO +: SH_W]
// to the incoming operand and registers it together with its sideband.
module shift_stage
    import shift_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int TAG_W = 5,
    parameter int SH_LO = 0,
    parameter int SH_W  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    in_data,
    input  shift_op_e          in_op,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_word,
    input  logic [TAG_W-1:0]   in_tag,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_data,
    output shift_op_e          out_op,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic               out_word,
    output logic [TAG_W-1:0]   out_tag
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both 1. ready never looks at valid; valid/data hold steady until taken.
    logic [SHAMT_W-1:0] amt;
    logic [6:0]         rot;
    logic [XLEN-1:0]    shifted;
    logic               load;

    always_comb begin
        amt     = SHAMT_W'(in_shamt[SH_LO+SH_W-1:SH_LO]) << SH_LO;
        rot     = 7'(XLEN) - {1'b0, amt};
        shifted = in_data;
        case (in_op)
            OP_SLL:  shifted = in_data << amt;
            OP_SRL:  shifted = in_data >> amt;
            OP_SRA:  shifted = XLEN'($signed(in_data) >>> amt);
            // rot == XLEN when amt == 0, so the wrap-around term shifts out to zero
            OP_ROR:  shifted = (in_data >> amt) | (in_data << rot);
            default: shifted = in_data;
        endcase
    end

    always_comb begin
        in_ready = (!out_valid || out_ready) && !flush;
        load     = in_valid && in_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_op    <= OP_SLL;
            out_shamt <= '0;
            out_word  <= 1'b0;
            out_tag   <= '0;
        end else begin
            if (flush) begin
                out_valid <= 1'b0;
            end else if (load) begin
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (load) begin
                out_data  <= shifted;
                out_op    <= in_op;
                out_shamt <= in_shamt;
                out_word  <= in_word;
                out_tag   <= in_tag;
            end
        end
    end

endmodule

// File: rtl/shift_pipe.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR plus 32-bit word variants) built from
// STAGES shift_stage slices with valid/ready flow control and a synchronous flush.
module shift_pipe
    import shift_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [XLEN-1:0]  in_a,
    input  logic [5:0]       in_shamt,
    input  logic [1:0]       in_op,
    input  logic             in_word,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int LOG = $clog2(XLEN);

    logic               v_c   [STAGES+1];
    logic               r_c   [STAGES+1];
    logic [XLEN-1:0]    d_c   [STAGES+1];
    shift_op_e          op_c  [STAGES+1];
    logic [SHAMT_W-1:0] sh_c  [STAGES+1];
    logic               w_c   [STAGES+1];
    logic [TAG_W-1:0]   tag_c [STAGES+1];

    shift_op_e          op_in;
    logic               word_eff;
    logic [63:0]        a_wide;
    logic [63:0]        a_pre64;
    logic [SHAMT_W-1:0] sh_eff;
    logic [XLEN-1:0]    d_last;
    logic               unused_tail;

    // Word ops are widened up front so the full-width slices need no word awareness.
    always_comb begin
        op_in    = shift_op_e'(in_op);
        word_eff = (XLEN == 64) && in_word;
        a_wide   = 64'(in_a);
        a_pre64  = a_wide;
        if (word_eff) begin
            case (op_in)
                OP_SRL:  a_pre64 = {32'h0, a_wide[31:0]};
                OP_SRA:  a_pre64 = {{32{a_wide[31]}}, a_wide[31:0]};
                OP_ROR:  a_pre64 = {a_wide[31:0], a_wide[31:0]};
                default: a_pre64 = a_wide;
            endcase
        end
        if (word_eff || (XLEN == 32)) begin
            sh_eff = {1'b0, in_shamt[4:0]};
        end else begin
            sh_eff = in_shamt;
        end
    end

    assign v_c[0]      = in_valid;
    assign d_c[0]      = XLEN'(a_pre64);
    assign op_c[0]     = op_in;
    assign sh_c[0]     = sh_eff;
    assign w_c[0]      = word_eff;
    assign tag_c[0]    = in_tag;
    assign in_ready    = r_c[0];
    assign r_c[STAGES] = out_ready;

    for (genvar g = 0; g < STAGES; g++) begin : g_stage
        localparam int SW = stage_bits(LOG, STAGES, g);
        localparam int SL = stage_lo(LOG, STAGES, g);

        shift_stage #(
            .XLEN  (XLEN),
            .TAG_W (TAG_W),
            .SH_LO (SL),
            .SH_W  (SW)
        ) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .in_valid  (v_c[g]),
            .in_ready  (r_c[g]),
            .in_data   (d_c[g]),
            .in_op     (op_c[g]),
            .in_shamt  (sh_c[g]),
            .in_word   (w_c[g]),
            .in_tag    (tag_c[g]),
            .out_valid (v_c[g+1]),
            .out_ready (r_c[g+1]),
            .out_data  (d_c[g+1]),
            .out_op    (op_c[g+1]),
            .out_shamt (sh_c[g+1]),
            .out_word  (w_c[g+1]),
            .out_tag   (tag_c[g+1])
        );
    end

    assign d_last      = d_c[STAGES];
    assign out_valid   = v_c[STAGES];
    assign out_tag     = tag_c[STAGES];
    assign out_result  = w_c[STAGES] ? XLEN'({{32{d_last[31]}}, d_last[31:0]}) : d_last;
    assign unused_tail = ^{op_c[STAGES], sh_c[STAGES]};

endmodule
